// File: rtl/pwm_code_rx.sv
// Pulse-width code receiver: sync pulse, CODE_WIDTH PWM bits MSB first, stop edge.
// Optional input glitch filter enabled by defining PWM_RX_DEGLITCH_EN.
module pwm_code_rx #(
  parameter int unsigned CODE_WIDTH    = 26,
  parameter int unsigned DATA_PERIOD   = 20,
  parameter int unsigned MARGIN        = 2,
  parameter int unsigned STOP_TIMEOUT  = 64,
  parameter int unsigned GLITCH_CYCLES = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  code_valid_out,
  input  logic                  code_ready_in,
  output logic                  err_out,
  output logic [2:0]            err_code_out,
  output logic [2:0]            state_out,
  output logic [15:0]           frames_ok_out
);

  localparam int unsigned HalfP  = DATA_PERIOD / 2;
  localparam int unsigned QuarP  = DATA_PERIOD / 4;
  localparam int unsigned ThreeQ = 3 * QuarP;
  localparam int unsigned MaxLen = (STOP_TIMEOUT > ThreeQ + MARGIN) ? STOP_TIMEOUT
                                                                    : ThreeQ + MARGIN;
  localparam int unsigned CntW   = $clog2(MaxLen + 2);
  localparam int unsigned IdxW   = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;

  localparam logic [CntW-1:0] HLo     = CntW'(HalfP - MARGIN);
  localparam logic [CntW-1:0] HHi     = CntW'(HalfP + MARGIN);
  localparam logic [CntW-1:0] QLo     = CntW'(QuarP - MARGIN);
  localparam logic [CntW-1:0] QHi     = CntW'(QuarP + MARGIN);
  localparam logic [CntW-1:0] TLo     = CntW'(ThreeQ - MARGIN);
  localparam logic [CntW-1:0] THi     = CntW'(ThreeQ + MARGIN);
  localparam logic [CntW-1:0] StopMax = CntW'(STOP_TIMEOUT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] IdxTop  = IdxW'(CODE_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSyncLo = 3'd1,
    StSyncHi = 3'd2,
    StBitLo  = 3'd3,
    StBitHi0 = 3'd4,
    StBitHi1 = 3'd5,
    StStop   = 3'd6
  } state_e;

  function automatic logic in_win(input logic [CntW-1:0] c, input logic [CntW-1:0] lo,
                                  input logic [CntW-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Synchroniser resets to the idle-high line level so reset never looks like a sync edge.
  logic sync1_q, sync2_q, line;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= data_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_RX_DEGLITCH_EN
  localparam int unsigned GlW = $clog2(GLITCH_CYCLES + 1);
  logic           filt_q, filt_d;
  logic [GlW-1:0] gl_cnt_q, gl_cnt_d;

  always_comb begin
    filt_d   = filt_q;
    gl_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (gl_cnt_q == GlW'(GLITCH_CYCLES - 1)) filt_d = sync2_q;
      else gl_cnt_d = gl_cnt_q + GlW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      filt_q   <= 1'b1;
      gl_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      gl_cnt_q <= gl_cnt_d;
    end
  end

  assign line = filt_q;
`else
  logic unused_glitch;
  assign unused_glitch = ^GLITCH_CYCLES;
  assign line = sync2_q;
`endif

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CODE_WIDTH-1:0] shift_q, shift_d, code_q, code_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [15:0]           frames_q, frames_d;
  logic                  done, fail, bit_done, bit_val;
  logic [2:0]            fail_code;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    code_d     = code_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    frames_d   = frames_q;
    done       = 1'b0;
    fail       = 1'b0;
    fail_code  = 3'd0;
    bit_done   = 1'b0;
    bit_val    = 1'b0;

    if (valid_q && code_ready_in) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!line) begin
          state_d = StSyncLo;
          cnt_d   = CntOne;
          idx_d   = IdxTop;
          shift_d = '0;
        end
      end
      StSyncLo: begin
        if (line) begin
          if (in_win(cnt_q, HLo, HHi)) begin
            state_d = StSyncHi;
            cnt_d   = CntOne;
          end else begin
            fail = 1'b1; fail_code = 3'd1;
          end
        end else if (cnt_q > HHi) begin
          fail = 1'b1; fail_code = 3'd1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StSyncHi: begin
        if (!line) begin
          if (in_win(cnt_q, HLo, HHi)) begin
            state_d = StBitLo;
            cnt_d   = CntOne;
          end else begin
            fail = 1'b1; fail_code = 3'd2;
          end
        end else if (cnt_q > HHi) begin
          fail = 1'b1; fail_code = 3'd2;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StBitLo: begin
        if (line) begin
          cnt_d = CntOne;
          if (in_win(cnt_q, QLo, QHi)) state_d = StBitHi0;
          else if (in_win(cnt_q, TLo, THi)) state_d = StBitHi1;
          else begin
            fail = 1'b1; fail_code = 3'd3;
          end
        end else if (cnt_q > THi) begin
          fail = 1'b1; fail_code = 3'd3;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StBitHi0, StBitHi1: begin
        bit_val = (state_q == StBitHi1);
        if (!line) begin
          if (bit_val ? in_win(cnt_q, QLo, QHi) : in_win(cnt_q, TLo, THi)) bit_done = 1'b1;
          else begin
            fail = 1'b1; fail_code = 3'd4;
          end
        end else if (cnt_q > (bit_val ? QHi : THi)) begin
          fail = 1'b1; fail_code = 3'd4;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (line) begin
          done    = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q > StopMax) begin
          fail = 1'b1; fail_code = 3'd5;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bit_done) begin
      shift_d[idx_q] = bit_val;
      cnt_d          = CntOne;
      if (idx_q == '0) begin
        state_d = StStop;
      end else begin
        idx_d   = idx_q - IdxW'(1);
        state_d = StBitLo;
      end
    end

    if (fail) begin
      state_d    = StIdle;
      cnt_d      = '0;
      idx_d      = IdxTop;
      shift_d    = '0;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end

    // A held code can be replaced in the same cycle the consumer takes it.
    if (done) begin
      if (!valid_q || code_ready_in) begin
        code_d  = shift_q;
        valid_d = 1'b1;
        if (frames_q != 16'hFFFF) frames_d = frames_q + 16'd1;
      end else begin
        err_d      = 1'b1;
        err_code_d = 3'd6;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= IdxTop;
      shift_q    <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      frames_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      frames_q   <= frames_d;
    end
  end

  assign code_out       = code_q;
  assign code_valid_out = valid_q;
  assign err_out        = err_q;
  assign err_code_out   = err_code_q;
  assign state_out      = state_q;
  assign frames_ok_out  = frames_q;

endmodule

// File: tb/tb_pwm_code_rx.sv
// Self-checking bench for pwm_code_rx: frame vector table, directed corner sequences and
// randomized frames against a frame-level delivery model.
module tb_pwm_code_rx;
  localparam int CW = 26;
  localparam int DP = 20;
  localparam int MG = 2;
  localparam int H  = DP / 2;
  localparam int Q  = DP / 4;
  localparam int G  = 3;
`ifdef PWM_RX_DEGLITCH_EN
  localparam int LAT = 3 + G;
`else
  localparam int LAT = 3;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, data_in, code_ready_in;
  logic [CW-1:0] code_out;
  logic          code_valid_out, err_out;
  logic [2:0]    err_code_out, state_out;
  logic [15:0]   frames_ok_out;

  pwm_code_rx #(
    .CODE_WIDTH   (CW),
    .DATA_PERIOD  (DP),
    .MARGIN       (MG),
    .STOP_TIMEOUT (64),
    .GLITCH_CYCLES(G)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .code_out      (code_out),
    .code_valid_out(code_valid_out),
    .code_ready_in (code_ready_in),
    .err_out       (err_out),
    .err_code_out  (err_code_out),
    .state_out     (state_out),
    .frames_ok_out (frames_ok_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  // Monitor owns these; the main process only reads them.
  int            mon_err[$];
  logic [CW-1:0] mon_acc[$];

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (err_out) mon_err.push_back(int'(err_code_out));
      if (code_valid_out && code_ready_in) mon_acc.push_back(code_out);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic level(input logic v, input int n);
    data_in = v;
    repeat (n) tick();
  endtask

  function automatic int adj(input int x, input int mode);
    case (mode)
      1:       return x + MG;
      2:       return x - MG;
      3:       return x + int'($urandom_range(2 * MG, 0)) - MG;
      default: return x;
    endcase
  endfunction

  // Leaves data_in high (stop edge) on return.
  task automatic send_frame(input logic [CW-1:0] code, input int mode, input int stop_lo,
                            input int bad_idx, input int bad_len, input int glitch_idx);
    level(1'b0, adj(H, mode));
    level(1'b1, adj(H, mode));
    for (int i = CW - 1; i >= 0; i--) begin
      int lo, hi;
      lo = code[i] ? 3 * Q : Q;
      hi = code[i] ? Q : 3 * Q;
      if (i == bad_idx) begin
        level(1'b0, bad_len);
      end else if (i == glitch_idx) begin
        level(1'b0, 6);
        level(1'b1, 2);
        level(1'b0, lo - 8);
      end else begin
        level(1'b0, adj(lo, mode));
      end
      level(1'b1, adj(hi, mode));
    end
    level(1'b0, stop_lo);
    data_in = 1'b1;
  endtask

  task automatic expect_delivery(input string name, input logic [CW-1:0] code);
    repeat (LAT - 1) tick();
    chk({name, "_early"}, code_valid_out, 1'b0);
    tick();
    chk({name, "_valid"}, code_valid_out, 1'b1);
    chk({name, "_code"}, code_out, code);
  endtask

  typedef struct {
    logic [CW-1:0] code;
    int            mode;
    int            bad_len;
    int            stop_lo;
    int            exp_err;
    bit            deliver;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int            eb, ab;
    bit            holding;
    logic [CW-1:0] held;
    int            exp_err_q[$];
    logic [CW-1:0] exp_acc_q[$];

    vecs[0] = '{26'h2AAAAAA, 0, 0, 10, 0, 1'b1};
    vecs[1] = '{26'h1234567, 1, 0, 10, 0, 1'b1};
    vecs[2] = '{26'h3C5A0F1, 2, 0, 10, 0, 1'b1};
    vecs[3] = '{26'h2AAAAAA, 0, 8, 10, 3, 1'b0};
    vecs[4] = '{26'h0000000, 0, 0, 5, 0, 1'b1};
    vecs[5] = '{26'h1555555, 0, 0, 70, 5, 1'b0};

    rst_in = 1'b1;
    data_in = 1'b1;
    code_ready_in = 1'b0;
    repeat (3) tick();
    chk("rst_code", code_out, '0);
    chk("rst_valid", code_valid_out, 1'b0);
    chk("rst_err", err_out, 1'b0);
    chk("rst_err_code", err_code_out, 3'd0);
    chk("rst_state", state_out, 3'd0);
    chk("rst_frames", frames_ok_out, 16'd0);
    rst_in = 1'b0;
    repeat (5) tick();

    for (int v = 0; v < 6; v++) begin
      eb = mon_err.size();
      ab = mon_acc.size();
      code_ready_in = 1'b1;
      send_frame(vecs[v].code, vecs[v].mode, vecs[v].stop_lo,
                 (vecs[v].bad_len != 0) ? 20 : -1, vecs[v].bad_len, -1);
      if (vecs[v].deliver) begin
        expect_delivery($sformatf("vec%0d", v), vecs[v].code);
        exp_frames++;
      end
      repeat (60) tick();
      chk($sformatf("vec%0d_first_err", v), (mon_err.size() > eb) ? mon_err[eb] : 0,
          vecs[v].exp_err);
      chk($sformatf("vec%0d_acc_cnt", v), mon_acc.size() - ab, int'(vecs[v].deliver));
      if (vecs[v].deliver)
        chk($sformatf("vec%0d_acc_code", v), mon_acc[ab], vecs[v].code);
      chk($sformatf("vec%0d_valid_end", v), code_valid_out, 1'b0);
      chk($sformatf("vec%0d_frames", v), frames_ok_out, exp_frames);
    end

    // Sync low too long, then a clean frame straight after.
    eb = mon_err.size();
    level(1'b0, 14);
    level(1'b1, 5);
    chk("sync14_err_cnt", mon_err.size() - eb, 1);
    chk("sync14_err_code", (mon_err.size() > eb) ? mon_err[eb] : 0, 1);
    chk("sync14_idle", state_out, 3'd0);
    send_frame(26'h0F0F0F0, 0, 10, -1, 0, -1);
    expect_delivery("after_sync14", 26'h0F0F0F0);
    exp_frames++;
    repeat (20) tick();

    // Overflow: hold A, drop B, replace A with C in the same cycle A is consumed.
    code_ready_in = 1'b0;
    send_frame(26'h1111111, 0, 10, -1, 0, -1);
    repeat (LAT + 5) tick();
    exp_frames++;
    chk("ovf_a_valid", code_valid_out, 1'b1);
    chk("ovf_a_code", code_out, 26'h1111111);
    eb = mon_err.size();
    send_frame(26'h2222222, 0, 10, -1, 0, -1);
    repeat (LAT + 5) tick();
    chk("ovf_b_err", (mon_err.size() > eb) ? mon_err[eb] : 0, 6);
    chk("ovf_b_code_kept", code_out, 26'h1111111);
    chk("ovf_b_valid", code_valid_out, 1'b1);
    chk("ovf_b_frames", frames_ok_out, exp_frames);
    eb = mon_err.size();
    ab = mon_acc.size();
    send_frame(26'h3333333, 0, 10, -1, 0, -1);
    repeat (LAT - 1) tick();
    code_ready_in = 1'b1;
    tick();
    code_ready_in = 1'b0;
    exp_frames++;
    chk("ovf_c_valid", code_valid_out, 1'b1);
    chk("ovf_c_code", code_out, 26'h3333333);
    repeat (5) tick();
    chk("ovf_c_no_err", mon_err.size() - eb, 0);
    chk("ovf_c_acc_cnt", mon_acc.size() - ab, 1);
    chk("ovf_c_acc_a", (mon_acc.size() > ab) ? mon_acc[ab] : '0, 26'h1111111);
    chk("ovf_c_frames", frames_ok_out, exp_frames);

    // Reset in the middle of a frame while code C is still held.
    level(1'b0, H);
    level(1'b1, H);
    for (int i = 0; i < 10; i++) begin
      level(1'b0, (i % 2) ? 3 * Q : Q);
      level(1'b1, (i % 2) ? Q : 3 * Q);
    end
    level(1'b0, 2);
    rst_in = 1'b1;
    data_in = 1'b1;
    tick();
    chk("mrst_code", code_out, '0);
    chk("mrst_valid", code_valid_out, 1'b0);
    chk("mrst_err_code", err_code_out, 3'd0);
    chk("mrst_state", state_out, 3'd0);
    chk("mrst_frames", frames_ok_out, 16'd0);
    rst_in = 1'b0;
    exp_frames = 0;
    repeat (5) tick();
    code_ready_in = 1'b1;
    send_frame(26'h2C3D4E5, 0, 10, -1, 0, -1);
    expect_delivery("post_rst", 26'h2C3D4E5);
    exp_frames++;
    tick();
    chk("post_rst_frames", frames_ok_out, exp_frames);
    repeat (20) tick();

`ifdef PWM_RX_DEGLITCH_EN
    eb = mon_err.size();
    send_frame(26'h1555555, 0, 10, -1, 0, 12);
    expect_delivery("glitch", 26'h1555555);
    exp_frames++;
    repeat (20) tick();
    chk("glitch_no_err", mon_err.size() - eb, 0);
`endif

    // Random frames, jittered within margin, random ready per frame.
    holding = 1'b0;
    held = '0;
    eb = mon_err.size();
    ab = mon_acc.size();
    for (int f = 0; f < 10; f++) begin
      bit            r;
      logic [CW-1:0] rc;
      r = 1'($urandom_range(1, 0));
      rc = CW'($urandom);
      code_ready_in = r;
      if (r && holding) begin
        exp_acc_q.push_back(held);
        holding = 1'b0;
      end
      send_frame(rc, 3, int'($urandom_range(30, 3)), -1, 0, -1);
      repeat (LAT + 3) tick();
      if (holding) begin
        exp_err_q.push_back(6);
      end else begin
        exp_frames++;
        if (r) exp_acc_q.push_back(rc);
        else begin
          holding = 1'b1;
          held = rc;
        end
      end
      repeat (int'($urandom_range(20, 5))) tick();
    end
    chk("rand_err_cnt", mon_err.size() - eb, exp_err_q.size());
    for (int i = 0; i < exp_err_q.size(); i++)
      chk($sformatf("rand_err%0d", i), (mon_err.size() > eb + i) ? mon_err[eb + i] : 0,
          exp_err_q[i]);
    chk("rand_acc_cnt", mon_acc.size() - ab, exp_acc_q.size());
    for (int i = 0; i < exp_acc_q.size(); i++)
      chk($sformatf("rand_acc%0d", i), (mon_acc.size() > ab + i) ? mon_acc[ab + i] : '0,
          exp_acc_q[i]);
    chk("rand_valid", code_valid_out, holding);
    if (holding) chk("rand_held_code", code_out, held);
    chk("rand_frames", frames_ok_out, exp_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
